// File: rtl/upsampler_pkg.sv
// Shared state type and elaboration-time helpers for the linear-interpolating upsampler.
package upsampler_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WAIT  = 2'd1,
      RUN   = 2'd2
   } state_t;

   function automatic int log2_ceil(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit factor_ok(input int f);
      return (f >= 2) && ((f & (f - 1)) == 0);
   endfunction

endpackage

// File: rtl/interp_accumulator.sv
// Signed slope accumulator: load latches start<<LOG2_F and end-start, step adds the slope once.
// out_val is the integer part of the accumulator; it reflects a load/step one cycle later.
module interp_accumulator #(
   parameter int DWIDTH    = 14,
   parameter int LOG2_F    = 8,
   parameter int ACC_WIDTH = DWIDTH + LOG2_F + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [DWIDTH-1:0] start_val,
   input  logic [DWIDTH-1:0] end_val,
   output logic [DWIDTH-1:0] out_val
);

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [DWIDTH:0]      delta;
   logic signed [ACC_WIDTH-1:0] delta_ext;

   assign delta_ext = {{(ACC_WIDTH - DWIDTH - 1){delta[DWIDTH]}}, delta};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= '0;
         delta <= '0;
      end else if (load) begin
         acc   <= {1'b0, start_val, {LOG2_F{1'b0}}};
         delta <= $signed({1'b0, end_val}) - $signed({1'b0, start_val});
      end else if (step) begin
         acc   <= acc + delta_ext;
      end
   end

   // acc stays within [0, max<<LOG2_F], so the arithmetic shift is just a slice
   assign out_val = acc[LOG2_F +: DWIDTH];

endmodule

// File: rtl/upsampler_interp.sv
// Raises sample rate by UPSAMPLE_FACTOR with linear interpolation; one output per ENABLE in RUN.
// Output lags the loading accept by 2 cycles; IN_READY drops once a sample waits in the hold register.
module upsampler_interp
   import upsampler_pkg::*;
#(
   parameter int DWIDTH          = 14,
   parameter int UPSAMPLE_FACTOR = 256,
   parameter int LOG2_F          = log2_ceil(UPSAMPLE_FACTOR),
   parameter int ACC_WIDTH       = DWIDTH + LOG2_F + 1
) (
   input  logic              CLOCK_IN,
   input  logic              RESET,
   input  logic              ENABLE,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DWIDTH-1:0] DATA_IN,
   output logic              OUT_VALID,
   output logic [DWIDTH-1:0] DATA_OUT
);

   generate
      if (!factor_ok(UPSAMPLE_FACTOR)) begin : g_bad_factor
         $error("UPSAMPLE_FACTOR must be a power of two and at least 2");
      end
   endgenerate

   localparam logic [LOG2_F-1:0] K_LAST = '1;

   state_t              state, state_nxt;
   logic [DWIDTH-1:0]   prev, next, hold;
   logic                hold_valid;
   logic [LOG2_F-1:0]   k;
   logic                accept, seg_end, acc_load, acc_step;
   logic [DWIDTH-1:0]   acc_start, acc_end, acc_out;

   assign IN_READY = RESET && ((state != RUN) || !hold_valid);
   assign accept   = IN_VALID && IN_READY;
   assign seg_end  = (state == RUN) && ENABLE && (k == K_LAST);
   assign acc_step = (state == RUN) && ENABLE;

   always_ff @(posedge CLOCK_IN) begin
      if (!RESET) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      acc_load  = 1'b0;
      acc_start = next;
      acc_end   = hold_valid ? hold : DATA_IN;
      case (state)
         EMPTY: if (accept) state_nxt = WAIT;
         WAIT: begin
            if (accept) begin
               state_nxt = RUN;
               acc_load  = 1'b1;
               acc_start = prev;
               acc_end   = DATA_IN;
            end
         end
         RUN: begin
            // a waiting sample at segment end chains the next segment with no gap
            if (seg_end) begin
               if (hold_valid || accept) acc_load  = 1'b1;
               else                      state_nxt = WAIT;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge CLOCK_IN) begin
      if (!RESET) begin
         prev       <= '0;
         next       <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         k          <= '0;
         DATA_OUT   <= '0;
         OUT_VALID  <= 1'b0;
      end else begin
         OUT_VALID <= 1'b0;
         case (state)
            EMPTY: if (accept) prev <= DATA_IN;
            WAIT: begin
               if (accept) begin
                  next <= DATA_IN;
                  k    <= '0;
               end
            end
            RUN: begin
               if (ENABLE) begin
                  DATA_OUT  <= acc_out;
                  OUT_VALID <= 1'b1;
                  k         <= k + 1'b1;
               end
               if (seg_end) begin
                  prev <= next;
                  if (hold_valid) begin
                     next       <= hold;
                     hold_valid <= 1'b0;
                  end else if (accept) begin
                     next <= DATA_IN;
                  end
               end else if (accept) begin
                  hold       <= DATA_IN;
                  hold_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   interp_accumulator #(
      .DWIDTH    (DWIDTH),
      .LOG2_F    (LOG2_F),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_acc (
      .clk       (CLOCK_IN),
      .rst_n     (RESET),
      .load      (acc_load),
      .step      (acc_step),
      .start_val (acc_start),
      .end_val   (acc_end),
      .out_val   (acc_out)
   );

endmodule

// File: tb/tb_upsampler_interp.sv
// Directed and random stimulus for upsampler_interp; expected samples come from a per-segment
// list built with plain arithmetic on every accepted pair of input samples.
module tb_upsampler_interp;

   localparam int DW = 14;
   localparam int FS = 4;

   logic          clk = 1'b0;
   logic          rst_n, en, in_vld;
   logic [DW-1:0] in_dat;
   logic          rdy_s, vld_s, rdy_b, vld_b;
   logic [DW-1:0] dat_s, dat_b;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int obs_q[$];
   int pulse_q[$];
   int want_q[$];
   int ncyc     = 0;
   int acc_cyc  = 0;
   int last_val = 0;
   int last_smp = 0;
   bit have_last = 1'b0;
   bit mon_on    = 1'b0;

   always #5 clk = ~clk;

   upsampler_interp #(.DWIDTH(DW), .UPSAMPLE_FACTOR(FS)) dut_s (
      .CLOCK_IN (clk),
      .RESET    (rst_n),
      .ENABLE   (en),
      .IN_VALID (in_vld),
      .IN_READY (rdy_s),
      .DATA_IN  (in_dat),
      .OUT_VALID(vld_s),
      .DATA_OUT (dat_s)
   );

   upsampler_interp #(.DWIDTH(DW)) dut_b (
      .CLOCK_IN (clk),
      .RESET    (rst_n),
      .ENABLE   (en),
      .IN_VALID (in_vld),
      .IN_READY (rdy_b),
      .DATA_IN  (in_dat),
      .OUT_VALID(vld_b),
      .DATA_OUT (dat_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   // straight line from a to b sampled at F points, floored
   function automatic void push_segment(input int a, input int b);
      for (int j = 0; j < FS; j++) exp_q.push_back((a * FS + j * (b - a)) / FS);
   endfunction

   always @(negedge clk) begin
      ncyc++;
      if (mon_on) begin
         if (vld_s) begin
            check("pulse_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("out_dat", dat_s, exp_q.pop_front());
            obs_q.push_back(int'(dat_s));
            pulse_q.push_back(ncyc);
            last_val = int'(dat_s);
         end else begin
            check("held_dat", dat_s, last_val);
         end
         if (!rst_n) begin
            exp_q.delete();
            have_last = 1'b0;
            last_val  = 0;
         end else if (in_vld && rdy_s) begin
            if (have_last) push_segment(last_smp, int'(in_dat));
            last_smp  = int'(in_dat);
            have_last = 1'b1;
            acc_cyc   = ncyc;
         end
      end
   end

   task automatic pulse_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      obs_q.delete();
      pulse_q.delete();
   endtask

   task automatic send(input int v, input bit expect_block);
      int n;
      n = 0;
      in_vld = 1'b1;
      in_dat = DW'(v);
      @(negedge clk);
      if (expect_block) check("rdy_blocked", rdy_s, 0);
      while (!rdy_s && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_accepted", rdy_s, 1);
      @(posedge clk); #1 in_vld = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      en = 1'b1;
      in_vld = 1'b0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      repeat (4) @(negedge clk);
      check({tag, "_drained"}, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_obs(input string tag);
      check({tag, "_count"}, obs_q.size(), want_q.size());
      for (int i = 0; i < want_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], want_q[i]);
   endtask

   task automatic pair_case(input string tag, input int a, input int b);
      pulse_reset();
      en = 1'b1;
      send(a, 1'b0);
      send(b, 1'b0);
      drain(tag);
      check_obs(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, gap, n;
      rst_n = 1'b0; en = 1'b0; in_vld = 1'b0; in_dat = '0;
      repeat (3) @(posedge clk);
      #1 mon_on = 1'b1;
      @(negedge clk);
      check("rst_vld", vld_s, 0);
      check("rst_dat", dat_s, 0);
      check("rst_rdy", rdy_s, 0);
      check("rst_rdy_b", rdy_b, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("empty_rdy", rdy_s, 1);
      @(posedge clk); #1;

      want_q = '{0, 25, 50, 75};
      pair_case("ramp_up", 0, 100);
      if (pulse_q.size() == 4) begin
         check("first_latency", pulse_q[0] - acc_cyc, 2);
         check("back_to_back", pulse_q[3] - pulse_q[0], 3);
      end
      want_q = '{100, 90, 80, 70};
      pair_case("ramp_down", 100, 60);
      want_q = '{3, 2, 1, 0};
      pair_case("small_down", 3, 0);
      want_q = '{0, 0, 1, 2};
      pair_case("floor_up", 0, 3);

      want_q = '{0, 4095, 8191, 12287, 16383, 12287, 8191, 4095};
      pulse_reset();
      en = 1'b1;
      send(0, 1'b0); send(16383, 1'b0); send(0, 1'b0);
      drain("full_scale");
      check_obs("full_scale");
      if (pulse_q.size() == 8) check("seamless", pulse_q[7] - pulse_q[0], 7);

      want_q = '{0, 25, 50, 75, 100, 85, 70, 55, 40, 49, 58, 67};
      pulse_reset();
      en = 1'b0;
      fork
         for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1 en = ~en;
         end
         begin
            send(0, 1'b0); send(100, 1'b0); send(40, 1'b0); send(77, 1'b1);
         end
      join
      drain("toggle");
      check_obs("toggle");
      gap = 1000;
      for (int i = 1; i < pulse_q.size(); i++)
         if (pulse_q[i] - pulse_q[i-1] < gap) gap = pulse_q[i] - pulse_q[i-1];
      check("toggle_min_gap", gap, 2);

      want_q = '{8, 10, 12, 14};
      pulse_reset();
      en = 1'b1;
      send(0, 1'b0); send(100, 1'b0);
      n = 0;
      while (pulse_q.size() < 2 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check("two_before_reset", pulse_q.size(), 2);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_vld", vld_s, 0);
      check("mid_rst_dat", dat_s, 0);
      check("mid_rst_rdy", rdy_s, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rdy", rdy_s, 1);
      @(posedge clk); #1;
      obs_q.delete();
      pulse_q.delete();
      send(8, 1'b0); send(16, 1'b0);
      drain("after_reset");
      check_obs("after_reset");

      pulse_reset();
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         en     = ($urandom_range(0, 3) != 0);
         in_vld = ($urandom_range(0, 1) != 0);
         in_dat = DW'($urandom);
         rst_n  = ($urandom_range(0, 199) != 0);
      end
      rst_n = 1'b1;
      drain("random");

      pulse_reset();
      en = 1'b1;
      send(0, 1'b0); send(256, 1'b0);
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (vld_b) begin
            check("f256_val", dat_b, cnt);
            cnt++;
         end
      end
      check("f256_pulses", cnt, 256);
      check("f256_wait_rdy", rdy_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
